status_reg: RTL

// - 6502/2A03 processor status register (P = N V 1 B D I Z C) directly downstream of the ALU.
// - Captures carry/overflow from the ALU and derives Z/N from the ALU result.
// - Serves SEx/CLx, PLP/RTI loads, BIT, interrupt entry and PHP/BRK push formatting.
// - Feeds the registered carry back to the ALU carry_in and supplies the interrupt mask to the IRQ logic.

---
 rtl/status_reg.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/status_reg.sv
// status_reg: 6502/2A03 processor status register (P = N V 1 B D I Z C).
// Sits directly after the ALU: takes carry/overflow, derives Z/N from the
// result, and serves flag set/clear, PLP/RTI loads, BIT, interrupt entry and
// PHP/BRK push formatting. The registered carry feeds the ALU carry_in and a
// delayed copy of I feeds the IRQ polling logic.
// Optional feature: define STATUS_BRANCH_EN to add br_cond/br_taken, a
// combinational conditional-branch decision from the current flags.
// Bits 5 and 4 are never stored; status_q always reports them as 1 and 0.

module status_reg #(
  parameter logic [7:0] RESET_P   = 8'h24,
  parameter int         FLAG_INIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       upd_en,
  input  logic [7:0] upd_mask,
  input  logic       bit_en,
  input  logic [7:0] mem_data,
  input  logic       ld_en,
  input  logic [7:0] ld_data,
  input  logic       sc_en,
  input  logic       sc_val,
  input  logic [2:0] sc_sel,
  input  logic       irq_entry,
  input  logic       instr_done,
  input  logic       push_brk,
  output logic [7:0] status_q,
  output logic       carry_q,
  output logic       irq_mask,
`ifdef STATUS_BRANCH_EN
  input  logic [2:0] br_cond,
  output logic       br_taken,
`endif
  output logic [7:0] push_p
);

  // Flag bit positions within P.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  // Reset image with the two unstored bits pinned to their fixed values.
  localparam logic [7:0] RESET_STORED = (RESET_P | 8'h20) & 8'hEF;
  localparam logic       IRQ_INIT     = (FLAG_INIT == 1) ? RESET_P[2] : 1'b1;

  logic [7:0] r_status;
  logic       r_irq_mask;

  logic [7:0] w_status_next;
  logic       w_irq_mask_next;
  logic       w_alu_zero;
  logic [7:0] w_alu_flags;
  logic [7:0] w_bit_flags;
  logic       w_sc_c;
  logic       w_sc_i;
  logic       w_sc_d;
  logic       w_sc_v;
  logic       w_unused_bits;

  // Flag values each source would write, laid out in P bit order.
  assign w_alu_zero  = (alu_result == 8'h00);
  assign w_alu_flags = {alu_result[7], alu_overflow, 4'b0000, w_alu_zero, alu_carry};
  assign w_bit_flags = {mem_data[7], mem_data[6], 4'b0000, w_alu_zero, 1'b0};

  // Single-flag set/clear decode; indices other than C/I/D/V are no-ops.
  assign w_sc_c = sc_en && (sc_sel == 3'(FLAG_C));
  assign w_sc_i = sc_en && (sc_sel == 3'(FLAG_I));
  assign w_sc_d = sc_en && (sc_sel == 3'(FLAG_D));
  assign w_sc_v = sc_en && (sc_sel == 3'(FLAG_V));

  // Mask bits for I/D/B/U and the stacked B/U bits have no effect.
  assign w_unused_bits = ^{upd_mask[5:2], ld_data[5:4], w_bit_flags[0]};

  // Next P: a stack load wins outright; otherwise each flag takes its
  // highest-priority active source (applied lowest first, later overrides).
  always_comb begin
    w_status_next = r_status;
    if (ld_en) begin
      w_status_next = ld_data;
    end else begin
      // ALU update, lowest priority, N/V/Z/C only.
      if (upd_en) begin
        if (upd_mask[FLAG_N]) w_status_next[FLAG_N] = w_alu_flags[FLAG_N];
        if (upd_mask[FLAG_V]) w_status_next[FLAG_V] = w_alu_flags[FLAG_V];
        if (upd_mask[FLAG_Z]) w_status_next[FLAG_Z] = w_alu_flags[FLAG_Z];
        if (upd_mask[FLAG_C]) w_status_next[FLAG_C] = w_alu_flags[FLAG_C];
      end
      // BIT owns N/V/Z; carry from a simultaneous ALU update survives.
      if (bit_en) begin
        w_status_next[FLAG_N] = w_bit_flags[FLAG_N];
        w_status_next[FLAG_V] = w_bit_flags[FLAG_V];
        w_status_next[FLAG_Z] = w_bit_flags[FLAG_Z];
      end
      // SEx/CLx instructions.
      if (w_sc_c) w_status_next[FLAG_C] = sc_val;
      if (w_sc_i) w_status_next[FLAG_I] = sc_val;
      if (w_sc_d) w_status_next[FLAG_D] = sc_val;
      if (w_sc_v) w_status_next[FLAG_V] = sc_val;
      // Interrupt/BRK entry masks further IRQs above everything else.
      if (irq_entry) w_status_next[FLAG_I] = 1'b1;
    end
    w_status_next[FLAG_U] = 1'b1;
    w_status_next[FLAG_B] = 1'b0;
  end

  // IRQ mask lags I by one instruction, except interrupt entry sets it now.
  always_comb begin
    w_irq_mask_next = r_irq_mask;
    if (irq_entry) begin
      w_irq_mask_next = 1'b1;
    end else if (instr_done) begin
      w_irq_mask_next = r_status[FLAG_I];
    end
  end

  // P register; async reset discards any write pending in the cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_status <= RESET_STORED;
    end else begin
      r_status <= w_status_next;
    end
  end

  // IRQ mask register sampled at instruction boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= IRQ_INIT;
    end else begin
      r_irq_mask <= w_irq_mask_next;
    end
  end

  assign status_q = r_status;
  assign carry_q  = r_status[FLAG_C];
  assign irq_mask = r_irq_mask;

  // Pushed image: B comes from the push source (1 for BRK/PHP, 0 for IRQ/NMI).
  assign push_p = {r_status[FLAG_N], r_status[FLAG_V], 1'b1, push_brk,
                   r_status[FLAG_D], r_status[FLAG_I], r_status[FLAG_Z], r_status[FLAG_C]};

`ifdef STATUS_BRANCH_EN
  logic w_br_flag;

  // Select the flag tested by the branch opcode group: N, V, C, Z.
  always_comb begin
    w_br_flag = r_status[FLAG_N];
    case (br_cond[2:1])
      2'd0:    w_br_flag = r_status[FLAG_N];
      2'd1:    w_br_flag = r_status[FLAG_V];
      2'd2:    w_br_flag = r_status[FLAG_C];
      default: w_br_flag = r_status[FLAG_Z];
    endcase
  end

  assign br_taken = (w_br_flag == br_cond[0]);
`endif

endmodule
